// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, the port index type and the address-check helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic port_t;

    localparam int unsigned MEM_BYTES_DEF = 1024;
    localparam int unsigned WORD_BYTES    = 4;
    localparam logic [1:0]  ALIGN_MASK    = 2'b11;

    // A word access is rejected when misaligned or when any of its bytes lies past the memory end.
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned mem_bytes);
        return ((addr[1:0] & ALIGN_MASK) != 2'b00) || (addr > 32'(mem_bytes - WORD_BYTES));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the priority port.
// Priority flips to the other port after every grant; reset favours port 0.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output port_t      gnt_port
);

    port_t prio;

    always_comb begin
        gnt_valid = en && (req != 2'b00);
        gnt_port  = (req == 2'b11) ? prio : port_t'(req[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (gnt_valid) begin
            prio <= ~gnt_port;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two word-wide requesters onto a single data memory with a fixed access latency.
// One transaction is in flight at a time: grant in IDLE, MEM_LAT cycles of ACCESS, one RESP cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_writeData,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    input  logic [31:0] mem_readData
);

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    port_t       lat_port;
    logic        lat_err;
    logic [31:0] rdata_q;

    logic        gnt_valid;
    port_t       gnt_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;
    logic        rsp_active;

    // Gating with rst_n keeps ready low while reset is held even though the FSM already sits in IDLE.
    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        ((state == IDLE) && rst_n),
        .req       ({req1_valid, req0_valid}),
        .gnt_valid (gnt_valid),
        .gnt_port  (gnt_port)
    );

    always_comb begin
        sel_we    = gnt_port ? req1_we    : req0_we;
        sel_addr  = gnt_port ? req1_addr  : req0_addr;
        sel_wdata = gnt_port ? req1_wdata : req0_wdata;
        sel_bad   = addr_bad(sel_addr, MEM_BYTES);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_valid) state_nxt = sel_bad ? RESP : ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_port  <= 1'b0;
            lat_err   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_valid) begin
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
                lat_port  <= gnt_port;
                lat_err   <= sel_bad;
                cnt       <= CNT_LOAD;
                rdata_q   <= '0;
            end else if (state == ACCESS) begin
                // rdata_q stays zero for writes and rejected requests, so RESP can drive it unconditionally.
                if (cnt == '0) begin
                    if (!lat_we) rdata_q <= mem_readData;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        req0_ready    = gnt_valid && (gnt_port == 1'b0);
        req1_ready    = gnt_valid && (gnt_port == 1'b1);

        mem_address   = lat_addr;
        mem_writeData = lat_wdata;
        mem_MemRead   = (state == ACCESS) && !lat_we;
        mem_MemWrite  = (state == ACCESS) && lat_we;

        rsp_active    = (state == RESP);
        rsp0_valid    = rsp_active && (lat_port == 1'b0);
        rsp1_valid    = rsp_active && (lat_port == 1'b1);
        rsp0_err      = rsp0_valid && lat_err;
        rsp1_err      = rsp1_valid && lat_err;
        rsp0_rdata    = rsp0_valid ? rdata_q : '0;
        rsp1_rdata    = rsp1_valid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus random two-port traffic,
// with expectations from a transaction-level model of arbitration, timing and memory contents.
module tb_dmem_arbiter;

    localparam int unsigned LAT   = 3;
    localparam int unsigned BYTES = 1024;
    localparam int unsigned WORDS = BYTES / 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_we;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_MemRead, mem_MemWrite;

    dmem_arbiter #(.MEM_LAT(LAT), .MEM_BYTES(BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_readData(mem_readData)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return {16'(i) ^ 16'h5A00, ~16'(i)};
    endfunction

    // Attached memory; junk on the read bus outside read strobes exposes mistimed captures.
    logic [31:0] tbmem [WORDS];
    logic        mem_up = 1'b0;
    assign mem_readData = mem_MemRead ? tbmem[mem_address[9:2]] : 32'hDEAD_BEEF;
    always @(posedge clk) begin
        if (!mem_up) begin
            for (int i = 0; i < int'(WORDS); i++) tbmem[i] <= init_word(i);
            mem_up <= 1'b1;
        end else if (mem_MemWrite) begin
            tbmem[mem_address[9:2]] <= mem_writeData;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model state
    typedef struct { logic [31:0] rdata; logic err; int due; } exp_t;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] ref_mem [WORDS];
    logic        last;
    int          next_free, acc_s, acc_e;
    logic        cur_we;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  mv, exp_rdy, exp_str;
    logic        gok, gp;

    task automatic model_accept(input logic p, input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic bad;
        bad = (a[1:0] != 2'b00) || (a > BYTES - 4);
        last = p;
        if (bad) begin
            e.rdata = '0; e.err = 1'b1; e.due = cyc + 1;
            next_free = cyc + 2;
        end else begin
            if (we) begin
                ref_mem[a[9:2]] = d;
                e.rdata = '0;
            end else begin
                e.rdata = ref_mem[a[9:2]];
            end
            e.err = 1'b0; e.due = cyc + int'(LAT) + 1;
            next_free = cyc + int'(LAT) + 2;
            acc_s = cyc + 1; acc_e = cyc + int'(LAT);
            cur_we = we; cur_addr = a; cur_wdata = d;
        end
        if (p) q1.push_back(e); else q0.push_back(e);
    endtask

    task automatic rsp_check(input int pp, input logic vld, input logic [31:0] rd, input logic er);
        exp_t e;
        logic have;
        have = (pp == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (pp == 0) ? q0[0] : q1[0];
        if (vld) begin
            if (!have) begin
                chk($sformatf("rsp%0d_unexpected", pp), 64'(vld), 64'd0);
            end else begin
                if (pp == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("rsp%0d_rdata", pp), 64'(rd), 64'(e.rdata));
                chk($sformatf("rsp%0d_err", pp), 64'(er), 64'(e.err));
                chk($sformatf("rsp%0d_cycle", pp), 64'(cyc), 64'(e.due));
            end
        end else if (have && e.due <= cyc) begin
            chk($sformatf("rsp%0d_missing", pp), 64'(vld), 64'd1);
            if (pp == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
    endtask

    // Monitor: arbitration, memory strobes and responses, all sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete(); q1.delete();
            last = 1'b1; next_free = 0; acc_s = 1; acc_e = 0;
        end else begin
            mv  = {req1_valid, req0_valid};
            gok = (mv != 2'b00) && (cyc >= next_free);
            gp  = (mv == 2'b11) ? ~last : mv[1];
            exp_rdy = gok ? (gp ? 2'b10 : 2'b01) : 2'b00;
            chk("ready", 64'({req1_ready, req0_ready}), 64'(exp_rdy));
            if (gok) begin
                if (gp) model_accept(1'b1, req1_we, req1_addr, req1_wdata);
                else    model_accept(1'b0, req0_we, req0_addr, req0_wdata);
            end
            exp_str = (cyc >= acc_s && cyc <= acc_e) ? (cur_we ? 2'b01 : 2'b10) : 2'b00;
            chk("strobe", 64'({mem_MemRead, mem_MemWrite}), 64'(exp_str));
            if (exp_str != 2'b00)
                chk("mem_bus", {mem_address, mem_writeData}, {cur_addr, cur_wdata});
            rsp_check(0, rsp0_valid, rsp0_rdata, rsp0_err);
            rsp_check(1, rsp1_valid, rsp1_rdata, rsp1_err);
        end
    end

    task automatic drive(input int p, input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        drive(p, 1'b1, we, a, d);
        do begin
            @(negedge clk);
            t++;
        end while (!((p == 0) ? req0_ready : req1_ready) && t < 300);
        if (t >= 300) chk($sformatf("req%0d_accept_timeout", p), 64'd0, 64'd1);
        @(posedge clk);
        #1 drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic drain_check(input string tag);
        repeat (LAT + 4) @(posedge clk);
        #1;
        chk({tag, "_q0_empty"}, 64'(q0.size()), 64'd0);
        chk({tag, "_q1_empty"}, 64'(q1.size()), 64'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        case ($urandom_range(0, 9))
            7:       a = a | 32'($urandom_range(1, 3));
            8:       a = 32'h3FC + 32'($urandom_range(0, 7));
            9:       a = $urandom;
            default: ;
        endcase
        return a;
    endfunction

    task automatic rand_port(input int p);
        repeat (30) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        // Reset state, with a request pending that must not be accepted yet
        repeat (3) @(posedge clk);
        #1 req0_valid = 1'b1;
        #1;
        chk("reset_ctl", 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
                              mem_MemRead, mem_MemWrite}), 64'd0);
        chk("reset_rdata", {rsp0_rdata, rsp1_rdata}, 64'd0);
        chk("reset_mem_bus", {mem_address, mem_writeData}, 64'd0);
        req0_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back through port 0
        send(0, 1'b1, 32'h10, 32'hA1B2_C3D4);
        send(0, 1'b0, 32'h10, 32'h0);
        drain_check("wr_rd");

        // Both ports saturated after reset: grants alternate starting with port 0
        reset_pulse();
        fork
            begin for (int unsigned k = 0; k < 4; k++) send(0, 1'b0, 32'h10 + 32'(4 * k), '0); end
            begin for (int unsigned k = 0; k < 4; k++) send(1, 1'b0, 32'h80 + 32'(4 * k), '0); end
        join
        drain_check("alternate");

        // Rejected requests and the top-of-memory boundary
        send(1, 1'b0, 32'h13, '0);
        send(0, 1'b0, 32'h3FD, '0);
        send(0, 1'b0, 32'h3FC, '0);
        send(1, 1'b1, 32'h400, 32'h1234_5678);
        send(1, 1'b1, 32'h3FC, 32'hCAFE_F00D);
        send(0, 1'b0, 32'h3FC, '0);
        drain_check("errors");

        // Random concurrent traffic on both ports
        fork
            rand_port(0);
            rand_port(1);
        join
        drain_check("random");

        // Reset in the middle of ACCESS abandons the read
        send(0, 1'b0, 32'h20, '0);
        @(posedge clk);
        #2;
        chk("pre_reset_strobe", 64'(mem_MemRead), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_strobe_drop", 64'({mem_MemRead, mem_MemWrite, rsp0_valid, rsp1_valid}), 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk);
        #1;
        send(0, 1'b0, 32'h20, '0);
        drain_check("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: actual timeout, expected completion (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, memory access cycles per transaction (range 1..15).
REQ-002 Parameter MEM_BYTES, default 1024, byte size of the attached data memory.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents a request.
REQ-006 reqN_ready  output  1  request of port N accepted this cycle.
REQ-007 reqN_we  input  1  1 = word write, 0 = word read.
REQ-008 reqN_addr  input  32  byte address.
REQ-009 reqN_wdata  input  32  write data, little-endian byte order.
REQ-010 rspN_valid  output  1  one-cycle response pulse to port N.
REQ-011 rspN_rdata  output  32  read data; 0 for writes and errors.
REQ-012 rspN_err  output  1  request rejected (misaligned or out of range).
REQ-013 mem_address  output  32  byte address to the data memory.
REQ-014 mem_writeData  output  32  write data to the data memory.
REQ-015 mem_MemRead  output  1  memory read strobe.
REQ-016 mem_MemWrite  output  1  memory write strobe.
REQ-017 mem_readData  input  32  read data from the data memory.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP.
REQ-019 IDLE: if either reqN_valid is set, grant one port, assert only its reqN_ready combinationally that cycle, latch we/addr/wdata/port.
REQ-020 Arbitration: round-robin; both valid -> port other than last granted wins; single valid -> that port wins regardless of pointer.
REQ-021 Pointer updates only on a grant; reset value favours port 0.
REQ-022 Check at grant: addr[1:0]!=0 or addr > MEM_BYTES-4 -> next state RESP with error flag; no memory strobe issued.
REQ-023 Valid request -> ACCESS for exactly MEM_LAT cycles, holding mem_address, mem_writeData and exactly one of mem_MemRead/mem_MemWrite high.
REQ-024 Reads: capture mem_readData on the last ACCESS cycle's rising edge.
REQ-025 RESP: exactly one cycle; rspN_valid=1 for the latched port only, rdata/err per REQ-011/REQ-012; then IDLE.
REQ-026 No reqN_ready in ACCESS or RESP; requests are held by requesters until accepted.
REQ-027 Latency: grant cycle to rspN_valid = MEM_LAT+1 cycles (valid access), 1 cycle (error).
REQ-028 Throughput: one transaction per MEM_LAT+2 cycles maximum.
REQ-029 Outside ACCESS: mem_MemRead=mem_MemWrite=0; mem_address/mem_writeData keep last latched value.
REQ-030 Access counter width 4 bits; loads MEM_LAT-1 on entry to ACCESS, decrements, no wrap.

Reset
REQ-031 rst_n low: FSM to IDLE, counter 0, pointer to port 0, all outputs 0, immediately (no clock needed).
REQ-032 Reset during ACCESS or RESP abandons the transaction; no response pulse follows reset release.
REQ-033 First grant possible on the first rising edge after rst_n goes high.

Structure
REQ-034 Package dmem_arb_pkg holds state enum, port-index type, MEM_BYTES default and error-check constants.
REQ-035 Sub-module rr_arb2 (two-way round-robin grant with pointer) is instantiated once; FSM, latch, counter stay in dmem_arbiter.

Verification
REQ-036 Port 0 write addr=0x10 data=0xA1B2C3D4, then read 0x10 -> mem_MemWrite one cycle, rsp0_rdata=0xA1B2C3D4, err=0.
REQ-037 Both valid every cycle, four reads each -> grants alternate 0,1,0,1,...; starting port 0 after reset.
REQ-038 Port 1 read addr=0x13 -> rsp1_err=1 one cycle after grant, rdata=0, no memory strobe.
REQ-039 Port 0 read addr=0x3FD (MEM_BYTES=1024) -> rsp0_err=1; addr=0x3FC -> err=0.
REQ-040 MEM_LAT=3, read -> mem_MemRead high exactly 3 cycles, rsp at grant+4.
REQ-041 rst_n low mid-ACCESS -> strobes drop asynchronously, no rsp pulse, next request served normally.
